// File: rtl/bt_bb_pkg.sv
// -----------------------------------------------------------------------------
// bt_bb_pkg
// Shared baseband definitions for the receive access-code correlator.
//   SYNC_W          : sync word length in bits
//   DEF_THRESH      : bit errors accepted when no threshold is programmed
//   corr_state_t    : correlator FSM states
//   exp_trailer_bit : expected first trailer bit for a given sync word LSB
// -----------------------------------------------------------------------------
package bt_bb_pkg;

    localparam int SYNC_W = 64;
    localparam logic [6:0] DEF_THRESH = 7'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_TRAIL  = 2'd2,
        ST_DONE   = 2'd3
    } corr_state_t;

    // The trailer continues the alternating pattern, so its first bit is the
    // complement of the last sync bit.
    function automatic logic exp_trailer_bit(input logic sw0);
        return ~sw0;
    endfunction

endpackage

// File: rtl/bt_popcount64.sv
// -----------------------------------------------------------------------------
// bt_popcount64
// Combinational 64-bit population count. The parent registers the result.
//   vec : input vector
//   cnt : number of ones in vec (0..64)
// -----------------------------------------------------------------------------
module bt_popcount64
    import bt_bb_pkg::*;
(
    input  logic [SYNC_W-1:0] vec,
    output logic [6:0]        cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < SYNC_W; i++) begin
            cnt = cnt + 7'(vec[i]);
        end
    end

endmodule

// File: rtl/accesscode_correlator.sv
// -----------------------------------------------------------------------------
// accesscode_correlator
// Receive access-code front end: slides a 64-bit window over rxbit (one sample
// per p_1us) and compares it against the selected sync word with a Hamming
// distance threshold. A match either starts the trailer/header chain
// (rx_trailer_st_p) or flags an ID packet (id_rcv_p).
//
// Ports:
//   clk_6M, rst                  : 6 MHz clock, synchronous active-high reset
//   p_1us, rxbit                 : bit sample strobe and demodulated bit
//   search_en                    : correlation window open
//   page/inquiry/conns/ps/mpr/spr: link state, selects sync word / packet type
//   regi_inquiryDIAC             : DIAC instead of GIAC while inquiring
//   regi_syncword_*              : expected sync words
//   regi_corr_thresh(_vld)       : programmed error threshold
//   rx_trailer_st_p              : trailer-start pulse, coincident with p_1us
//   id_rcv_p                     : ID packet received
//   sync_found                   : sync word accepted in current window
//   sync_miss_p                  : window closed without a match
//   corr_errors                  : error count of the accepted match
//   trailer_err_p                : first trailer bit wrong (only with
//                                  ACCESS_TRAILER_CHECK_EN, else tied 0)
//
// Build option: define ACCESS_TRAILER_CHECK_EN to inspect trailer bit 68.
// -----------------------------------------------------------------------------
module accesscode_correlator
    import bt_bb_pkg::*;
#(
    parameter int CNT_W = 7
)
(
    input  logic              clk_6M,
    input  logic              rst,
    input  logic              p_1us,
    input  logic              rxbit,
    input  logic              search_en,
    input  logic              page,
    input  logic              inquiry,
    input  logic              conns,
    input  logic              ps,
    input  logic              mpr,
    input  logic              spr,
    input  logic              regi_inquiryDIAC,
    input  logic [SYNC_W-1:0] regi_syncword_CAC,
    input  logic [SYNC_W-1:0] regi_syncword_DAC,
    input  logic [SYNC_W-1:0] regi_syncword_DIAC,
    input  logic [SYNC_W-1:0] regi_syncword_GIAC,
    input  logic [CNT_W-1:0]  regi_corr_thresh,
    input  logic              regi_corr_thresh_vld,
    output logic              rx_trailer_st_p,
    output logic              id_rcv_p,
    output logic              sync_found,
    output logic              sync_miss_p,
    output logic [CNT_W-1:0]  corr_errors,
    output logic              trailer_err_p
);

    corr_state_t       state;
    logic [SYNC_W-1:0] sr;
    logic [SYNC_W-1:0] syncword;
    logic [CNT_W-1:0]  fill;
    logic [CNT_W-1:0]  err;
    logic [CNT_W-1:0]  thresh;
    logic [6:0]        pc;
    logic [1:0]        tcnt;
    logic              tick_d;
    logic              err_vld;
    logic              id_q;
    logic              miss_q;
    logic              match;
    logic              id_type;
    logic              trail_fire;
    logic              trl_err;

    always_comb begin
        if (conns)
            syncword = regi_syncword_CAC;
        else if (page | ps | mpr | spr)
            syncword = regi_syncword_DAC;
        else if (regi_inquiryDIAC)
            syncword = regi_syncword_DIAC;
        else
            syncword = regi_syncword_GIAC;
    end

    assign thresh  = regi_corr_thresh_vld ? regi_corr_thresh : CNT_W'(DEF_THRESH);
    assign id_type = page | inquiry | spr;

    bt_popcount64 u_pc (
        .vec (sr ^ syncword),
        .cnt (pc)
    );

    // err/err_vld describe the window shifted in two clocks earlier; the
    // decision lands well before the next sample tick.
    assign match = (state == ST_SEARCH) && err_vld && (err <= thresh);

    // Second tick after the last sync bit samples trailer bit 69.
    assign trail_fire = (state == ST_TRAIL) && p_1us && (tcnt == 2'd1);

`ifdef ACCESS_TRAILER_CHECK_EN
    assign trl_err = (state == ST_TRAIL) && p_1us && (tcnt == 2'd0) &&
                     (rxbit != exp_trailer_bit(syncword[0]));
`else
    assign trl_err = 1'b0;
`endif

    // Pulses are masked during reset so nothing escapes in the reset cycle.
    assign rx_trailer_st_p = trail_fire & ~rst;
    assign trailer_err_p   = trl_err & ~rst;
    assign id_rcv_p        = id_q & ~rst;
    assign sync_miss_p     = miss_q & ~rst;

    always_ff @(posedge clk_6M) begin
        if (rst) begin
            state       <= ST_IDLE;
            sr          <= '0;
            fill        <= '0;
            err         <= '0;
            tick_d      <= 1'b0;
            err_vld     <= 1'b0;
            tcnt        <= '0;
            id_q        <= 1'b0;
            miss_q      <= 1'b0;
            sync_found  <= 1'b0;
            corr_errors <= '0;
        end else begin
            id_q    <= 1'b0;
            miss_q  <= 1'b0;
            tick_d  <= (state == ST_SEARCH) && p_1us;
            err_vld <= tick_d && (state == ST_SEARCH) && (fill == CNT_W'(SYNC_W));
            err     <= CNT_W'(pc);

            case (state)
                ST_IDLE: begin
                    if (search_en) begin
                        fill  <= '0;
                        state <= ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    if (p_1us) begin
                        sr <= {sr[SYNC_W-2:0], rxbit};
                        if (fill != CNT_W'(SYNC_W))
                            fill <= fill + 1'b1;
                    end
                    // A match decided in the closing cycle still counts.
                    if (match) begin
                        sync_found  <= 1'b1;
                        corr_errors <= err;
                        if (id_type) begin
                            id_q  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            tcnt  <= '0;
                            state <= ST_TRAIL;
                        end
                    end else if (!search_en) begin
                        miss_q <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                ST_TRAIL: begin
                    // search_en is ignored here: the trailer pulse always issues.
                    if (trl_err) begin
                        sync_found <= 1'b0;
                        fill       <= '0;
                        state      <= ST_SEARCH;
                    end else if (p_1us) begin
                        tcnt <= tcnt + 1'b1;
                        if (tcnt == 2'd1)
                            state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!search_en) begin
                        sync_found <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_accesscode_correlator.sv
// -----------------------------------------------------------------------------
// tb_accesscode_correlator
// Directed-vector bench for accesscode_correlator. Bits are applied one per
// p_1us (every 6 clocks); a negedge monitor records pulse counts and the cycle
// of their last occurrence, which are compared against hand-derived values.
// -----------------------------------------------------------------------------
module tb_accesscode_correlator;

    localparam logic [63:0] CAC  = 64'h2C7E_93A1_5B0D_E4F7;
    localparam logic [63:0] DAC  = 64'h4E1B_86D3_72A9_C05E;
    localparam logic [63:0] DIAC = 64'h9D35_0B6E_E1C4_27A8;
    localparam logic [63:0] GIAC = 64'hF0F0_0000_0000_000F;  // 12 ones
    localparam logic [63:0] M7   = 64'h8001_0100_0020_0481;  // 7 ones
    localparam logic [63:0] M8   = 64'h8001_0100_0220_0481;  // 8 ones
`ifdef ACCESS_TRAILER_CHECK_EN
    localparam int TCHK = 1;
`else
    localparam int TCHK = 0;
`endif

    logic        clk_6M = 1'b0;
    logic        rst, p_1us, rxbit, search_en;
    logic        page, inquiry, conns, ps, mpr, spr, regi_inquiryDIAC;
    logic [63:0] regi_syncword_CAC, regi_syncword_DAC, regi_syncword_DIAC, regi_syncword_GIAC;
    logic [6:0]  regi_corr_thresh;
    logic        regi_corr_thresh_vld;
    logic        rx_trailer_st_p, id_rcv_p, sync_found, sync_miss_p, trailer_err_p;
    logic [6:0]  corr_errors;

    accesscode_correlator dut (
        .clk_6M              (clk_6M),
        .rst                 (rst),
        .p_1us               (p_1us),
        .rxbit               (rxbit),
        .search_en           (search_en),
        .page                (page),
        .inquiry             (inquiry),
        .conns               (conns),
        .ps                  (ps),
        .mpr                 (mpr),
        .spr                 (spr),
        .regi_inquiryDIAC    (regi_inquiryDIAC),
        .regi_syncword_CAC   (regi_syncword_CAC),
        .regi_syncword_DAC   (regi_syncword_DAC),
        .regi_syncword_DIAC  (regi_syncword_DIAC),
        .regi_syncword_GIAC  (regi_syncword_GIAC),
        .regi_corr_thresh    (regi_corr_thresh),
        .regi_corr_thresh_vld(regi_corr_thresh_vld),
        .rx_trailer_st_p     (rx_trailer_st_p),
        .id_rcv_p            (id_rcv_p),
        .sync_found          (sync_found),
        .sync_miss_p         (sync_miss_p),
        .corr_errors         (corr_errors),
        .trailer_err_p       (trailer_err_p)
    );

    always #5 clk_6M = ~clk_6M;

    int cyc = 0;
    always @(posedge clk_6M) cyc <= cyc + 1;

    int n_trail = 0, n_id = 0, n_miss = 0, n_terr = 0;
    int trail_cyc = -1, id_cyc = -1, terr_cyc = -1;
    always @(negedge clk_6M) begin
        if (rx_trailer_st_p) begin n_trail++; trail_cyc = cyc; end
        if (id_rcv_p)        begin n_id++;    id_cyc    = cyc; end
        if (sync_miss_p)     n_miss++;
        if (trailer_err_p)   begin n_terr++;  terr_cyc  = cyc; end
    end

    int n_vec = 0, n_err = 0;
    int tb, t_last, t68, t69;
    int b_trail, b_id, b_miss, b_terr;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(posedge clk_6M); #2;
        p_1us = 1'b1;
        rxbit = b;
        tb    = cyc;
        @(posedge clk_6M); #2;
        p_1us = 1'b0;
        repeat (4) @(posedge clk_6M);
        #2;
    endtask

    task automatic send_pre();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    endtask

    task automatic send_sync(input logic [63:0] sw, input logic [63:0] mask);
        for (int i = 63; i >= 0; i--) send_bit(sw[i] ^ mask[i]);
        t_last = tb;
    endtask

    task automatic send_trailer(input logic b68);
        send_bit(b68);  t68 = tb;
        send_bit(~b68); t69 = tb;
        send_bit(b68);
        send_bit(~b68);
    endtask

    task automatic send_rand(input int n);
        for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
    endtask

    task automatic mark();
        b_trail = n_trail; b_id = n_id; b_miss = n_miss; b_terr = n_terr;
    endtask

    task automatic open_win();
        search_en = 1'b1;
        repeat (2) @(posedge clk_6M);
        #2;
    endtask

    task automatic close_win();
        search_en = 1'b0;
        repeat (4) @(posedge clk_6M);
        #2;
    endtask

    task automatic set_link(input logic c, input logic pg, input logic iq, input logic dsel);
        conns = c; page = pg; inquiry = iq; regi_inquiryDIAC = dsel;
    endtask

    initial begin
        logic [63:0] sw;
        rst = 1'b1; p_1us = 1'b0; rxbit = 1'b0; search_en = 1'b0;
        page = 1'b0; inquiry = 1'b0; conns = 1'b0; ps = 1'b0; mpr = 1'b0; spr = 1'b0;
        regi_inquiryDIAC   = 1'b0;
        regi_syncword_CAC  = CAC;
        regi_syncword_DAC  = DAC;
        regi_syncword_DIAC = DIAC;
        regi_syncword_GIAC = GIAC;
        regi_corr_thresh = 7'd0; regi_corr_thresh_vld = 1'b1;
        repeat (3) @(posedge clk_6M);
        #2;
        chk("rst_trail", int'(rx_trailer_st_p), 0);
        chk("rst_id",    int'(id_rcv_p), 0);
        chk("rst_found", int'(sync_found), 0);
        chk("rst_miss",  int'(sync_miss_p), 0);
        chk("rst_err",   int'(corr_errors), 0);
        chk("rst_terr",  int'(trailer_err_p), 0);
        rst = 1'b0;

        // CAC exact match, threshold 0
        set_link(1, 0, 0, 0);
        open_win(); mark();
        send_pre(); send_sync(CAC, 64'h0); send_trailer(1'b0);
        chk("cac_trail_n",  n_trail - b_trail, 1);
        chk("cac_trail_at", trail_cyc, t69);
        chk("cac_errs",     int'(corr_errors), 0);
        chk("cac_found",    int'(sync_found), 1);
        chk("cac_id_n",     n_id - b_id, 0);
        close_win();
        chk("cac_found_clr", int'(sync_found), 0);

        // Default threshold, 7 errors accepted
        regi_corr_thresh_vld = 1'b0;
        open_win(); mark();
        send_pre(); send_sync(CAC, M7); send_trailer(1'b0);
        chk("e7_trail_n",  n_trail - b_trail, 1);
        chk("e7_trail_at", trail_cyc, t69);
        chk("e7_errs",     int'(corr_errors), 7);
        close_win();

        // 8 errors rejected, window close reports one miss
        open_win(); mark();
        send_pre(); send_sync(CAC, M8); send_trailer(1'b0);
        chk("e8_trail_n", n_trail - b_trail, 0);
        chk("e8_found",   int'(sync_found), 0);
        close_win();
        chk("e8_miss_n",  n_miss - b_miss, 1);

        // ID packet on DAC while paging
        regi_corr_thresh_vld = 1'b1; regi_corr_thresh = 7'd0;
        set_link(0, 1, 0, 0);
        open_win(); mark();
        send_pre(); send_sync(DAC, 64'h0); send_trailer(~DAC[0]);
        chk("id_n",       n_id - b_id, 1);
        chk("id_at",      id_cyc, t_last + 3);
        chk("id_trail_n", n_trail - b_trail, 0);
        chk("id_found",   int'(sync_found), 1);
        close_win();

        // Threshold 64 matches the first full window (GIAC, all-zero data)
        set_link(0, 0, 1, 0);
        regi_corr_thresh = 7'd64;
        open_win(); mark();
        send_sync(64'h0, 64'h0); send_bit(1'b0);
        chk("t64_id_n", n_id - b_id, 1);
        chk("t64_id_at", id_cyc, t_last + 3);
        chk("t64_errs", int'(corr_errors), 12);
        close_win();

        // DIAC selected by register while inquiring
        set_link(0, 0, 1, 1);
        regi_corr_thresh = 7'd0;
        open_win(); mark();
        send_pre(); send_sync(DIAC, 64'h0); send_bit(1'b0);
        chk("diac_id_n", n_id - b_id, 1);
        chk("diac_errs", int'(corr_errors), 0);
        close_win();

        // 63 CAC bits then a wrong bit and random data: no match
        set_link(1, 0, 0, 0);
        sw = CAC;
        open_win(); mark();
        send_pre();
        for (int i = 63; i >= 1; i--) send_bit(sw[i]);
        send_bit(~sw[0]);
        send_rand(20);
        chk("mis_trail_n", n_trail - b_trail, 0);
        chk("mis_found",   int'(sync_found), 0);
        close_win();

        // Random prefix then CAC: match only at the true alignment
        open_win(); mark();
        send_rand(40); send_sync(CAC, 64'h0); send_trailer(1'b0);
        chk("pre_trail_n",  n_trail - b_trail, 1);
        chk("pre_trail_at", trail_cyc, t69);
        close_win();

        // Reset during TRAIL, coincident with the pulse tick
        open_win(); mark();
        send_pre(); send_sync(CAC, 64'h0); send_bit(1'b0);
        @(posedge clk_6M); #2;
        p_1us = 1'b1; rxbit = 1'b1; rst = 1'b1;
        @(posedge clk_6M); #2;
        p_1us = 1'b0; rst = 1'b0;
        chk("rstT_found", int'(sync_found), 0);
        repeat (6) @(posedge clk_6M);
        #2;
        chk("rstT_trail_n", n_trail - b_trail, 0);
        close_win();

        // search_en dropped during TRAIL: pulse still issued
        open_win(); mark();
        send_pre(); send_sync(CAC, 64'h0);
        search_en = 1'b0;
        send_trailer(1'b0);
        chk("drop_trail_n",  n_trail - b_trail, 1);
        chk("drop_trail_at", trail_cyc, t69);
        chk("drop_found",    int'(sync_found), 0);
        chk("drop_miss_n",   n_miss - b_miss, 0);
        close_win();

        // Wrong trailer bit 68 (CAC[0] = 1, so bit 68 should be 0)
        open_win(); mark();
        send_pre(); send_sync(CAC, 64'h0); send_trailer(1'b1);
        chk("terr_n",       n_terr - b_terr, TCHK);
        chk("terr_trail_n", n_trail - b_trail, 1 - TCHK);
        if (TCHK == 1) begin
            chk("terr_at",    terr_cyc, t68);
            chk("terr_found", int'(sync_found), 0);
            mark();
            send_pre(); send_sync(CAC, 64'h0); send_trailer(1'b0);
            chk("terr_resume_n",  n_trail - b_trail, 1);
            chk("terr_resume_at", trail_cyc, t69);
        end
        close_win();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
